// File: rtl/mem_arbiter.sv
// Round-robin N-client front end for the single-channel memory block: tags each request
// with its client index, caps in-flight requests per client and steers tagged responses back.
module mem_arbiter #(
    parameter int NUM_CLIENTS     = 2,
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              buffer_addr_valid,
    input  logic [NUM_CLIENTS-1:0]            cl_req_valid,
    output logic [NUM_CLIENTS-1:0]            cl_req_ready,
    input  logic [NUM_CLIENTS-1:0]            cl_req_write,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_req_data,
    output logic [NUM_CLIENTS-1:0]            cl_rsp_valid,
    output logic                              cl_rsp_write,
    output logic [DATA_WIDTH-1:0]             cl_rsp_data,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_req_write,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    output logic [DATA_WIDTH-1:0]             mem_req_data,
    output logic [TAG_WIDTH-1:0]              mem_req_tag,
    input  logic                              mem_rsp_valid,
    input  logic                              mem_rsp_write,
    input  logic [TAG_WIDTH-1:0]              mem_rsp_tag,
    input  logic [DATA_WIDTH-1:0]             mem_rsp_data,
    output logic                              err
);

    localparam logic [TAG_WIDTH:0] NC_W    = (TAG_WIDTH+1)'(NUM_CLIENTS);
    localparam logic [3:0]         MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [TAG_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]             outst_q [NUM_CLIENTS];
    logic [3:0]             outst_d [NUM_CLIENTS];
    logic                   occ_q, occ_d;
    logic                   req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]  req_data_q, req_data_d;
    logic [TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
    logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    logic                   rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   err_q, err_d;

    logic                   can_load_s;
    logic [NUM_CLIENTS-1:0] eligible_s, grant_s, inc_s, dec_s, zero_s;
    logic                   grant_any_s, hit_s;
    logic [TAG_WIDTH-1:0]   grant_idx_s;
    logic [TAG_WIDTH:0]     sum_s, cand_s, nxt_s;
    logic                   rsp_tag_ok_s, rsp_deliver_s;

    // Next-state logic: eligibility, round-robin pick, output register, response steering, counters.
    always_comb begin
        can_load_s  = !occ_q || mem_req_ready;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        hit_s       = 1'b0;
        sum_s       = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            eligible_s[i] = cl_req_valid[i] && buffer_addr_valid && !rst
                            && (outst_q[i] < MAX_OUT) && can_load_s;
        end
        // First eligible client at or after rr_ptr wins; indices wrap modulo NUM_CLIENTS.
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            sum_s       = {1'b0, rr_ptr_q} + (TAG_WIDTH+1)'(k);
            cand_s      = (sum_s >= NC_W) ? (sum_s - NC_W) : sum_s;
            hit_s       = !grant_any_s && eligible_s[cand_s[TAG_WIDTH-1:0]];
            grant_idx_s = hit_s ? cand_s[TAG_WIDTH-1:0] : grant_idx_s;
            grant_any_s = grant_any_s || hit_s;
        end
        grant_s  = grant_any_s ? (NUM_CLIENTS'(1) << grant_idx_s) : '0;
        nxt_s    = {1'b0, grant_idx_s} + (TAG_WIDTH+1)'(1);
        rr_ptr_d = grant_any_s ? ((nxt_s >= NC_W) ? '0 : nxt_s[TAG_WIDTH-1:0]) : rr_ptr_q;

        occ_d = grant_any_s || (occ_q && !mem_req_ready);
        if (grant_any_s) begin
            req_write_d = cl_req_write[grant_idx_s];
            req_addr_d  = cl_req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            req_data_d  = cl_req_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            req_tag_d   = grant_idx_s;
        end else begin
            req_write_d = req_write_q;
            req_addr_d  = req_addr_q;
            req_data_d  = req_data_q;
            req_tag_d   = req_tag_q;
        end

        rsp_tag_ok_s  = ({1'b0, mem_rsp_tag} < NC_W);
        rsp_deliver_s = mem_rsp_valid && rsp_tag_ok_s;
        rsp_write_d   = rsp_deliver_s ? mem_rsp_write : rsp_write_q;
        rsp_data_d    = rsp_deliver_s ? mem_rsp_data : rsp_data_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rsp_valid_d[i] = rsp_deliver_s && (mem_rsp_tag == TAG_WIDTH'(i));
            zero_s[i]      = (outst_q[i] == 4'd0);
            inc_s[i]       = grant_s[i];
            dec_s[i]       = rsp_valid_d[i] && !zero_s[i];
            case ({inc_s[i], dec_s[i]})
                2'b10:   outst_d[i] = outst_q[i] + 4'd1;
                2'b01:   outst_d[i] = outst_q[i] - 4'd1;
                default: outst_d[i] = outst_q[i];
            endcase
        end
        // A response to a client with nothing in flight is still delivered but flagged.
        err_d = err_q || (mem_rsp_valid && !rsp_tag_ok_s) || (|(rsp_valid_d & zero_s));
    end

    // State registers with synchronous reset; an in-flight request is discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            occ_q       <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                outst_q[i] <= 4'd0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            occ_q       <= occ_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_tag_q   <= req_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign cl_req_ready  = grant_s;
    assign cl_rsp_valid  = rsp_valid_q;
    assign cl_rsp_write  = rsp_write_q;
    assign cl_rsp_data   = rsp_data_q;
    assign mem_req_valid = occ_q;
    assign mem_req_write = req_write_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_data  = req_data_q;
    assign mem_req_tag   = req_tag_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 4-client/limit-2 instance for arbitration, backpressure,
// limits and routing, plus a 3-client instance for out-of-range tag handling.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, bav;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            rsp_write;
    logic [DW-1:0]   rsp_data;
    logic            mreq_valid, mreq_ready, mreq_write;
    logic [AW-1:0]   mreq_addr;
    logic [DW-1:0]   mreq_data;
    logic [1:0]      mreq_tag;
    logic            mrsp_valid, mrsp_write;
    logic [1:0]      mrsp_tag;
    logic [DW-1:0]   mrsp_data;
    logic            err;

    logic [2:0]      c3_req_valid, c3_req_write, c3_req_ready, c3_rsp_valid;
    logic [3*AW-1:0] c3_req_addr;
    logic [3*DW-1:0] c3_req_data;
    logic            c3_rsp_write, c3_mreq_valid, c3_mreq_write;
    logic [DW-1:0]   c3_rsp_data, c3_mreq_data, c3_mrsp_data;
    logic [AW-1:0]   c3_mreq_addr;
    logic [1:0]      c3_mreq_tag, c3_mrsp_tag;
    logic            c3_mrsp_valid, c3_mrsp_write, c3_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst), .buffer_addr_valid(bav),
        .cl_req_valid(req_valid), .cl_req_ready(req_ready), .cl_req_write(req_write),
        .cl_req_addr(req_addr), .cl_req_data(req_data),
        .cl_rsp_valid(rsp_valid), .cl_rsp_write(rsp_write), .cl_rsp_data(rsp_data),
        .mem_req_valid(mreq_valid), .mem_req_ready(mreq_ready), .mem_req_write(mreq_write),
        .mem_req_addr(mreq_addr), .mem_req_data(mreq_data), .mem_req_tag(mreq_tag),
        .mem_rsp_valid(mrsp_valid), .mem_rsp_write(mrsp_write), .mem_rsp_tag(mrsp_tag),
        .mem_rsp_data(mrsp_data), .err(err)
    );

    mem_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut3 (
        .clk(clk), .rst(rst), .buffer_addr_valid(bav),
        .cl_req_valid(c3_req_valid), .cl_req_ready(c3_req_ready), .cl_req_write(c3_req_write),
        .cl_req_addr(c3_req_addr), .cl_req_data(c3_req_data),
        .cl_rsp_valid(c3_rsp_valid), .cl_rsp_write(c3_rsp_write), .cl_rsp_data(c3_rsp_data),
        .mem_req_valid(c3_mreq_valid), .mem_req_ready(mreq_ready), .mem_req_write(c3_mreq_write),
        .mem_req_addr(c3_mreq_addr), .mem_req_data(c3_mreq_data), .mem_req_tag(c3_mreq_tag),
        .mem_rsp_valid(c3_mrsp_valid), .mem_rsp_write(c3_mrsp_write), .mem_rsp_tag(c3_mrsp_tag),
        .mem_rsp_data(c3_mrsp_data), .err(c3_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic v, input logic [1:0] t, input logic [DW-1:0] d, input logic w);
        mrsp_valid = v;
        mrsp_tag   = t;
        mrsp_data  = d;
        mrsp_write = w;
    endtask

    initial begin
        rst = 1'b1; bav = 1'b1; req_valid = 4'b1111; req_write = 4'b1010; mreq_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 8'h10 + 8'(i);
            req_data[i*DW +: DW] = 16'hD000 + 16'(i);
        end
        rsp(1'b0, 2'd0, 16'h0, 1'b0);
        c3_req_valid = 3'b000; c3_req_write = 3'b000; c3_req_addr = '0; c3_req_data = '0;
        c3_mrsp_valid = 1'b0; c3_mrsp_write = 1'b0; c3_mrsp_tag = 2'd0; c3_mrsp_data = 16'h0;

        // Reset held two cycles with every client requesting
        tick(); tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_mreq_valid", 64'(mreq_valid), 64'h0);
        chk("rst_mreq_tag_addr", 64'({mreq_tag, mreq_addr, mreq_data}), 64'h0);
        chk("rst_rsp", 64'({rsp_valid, rsp_write, rsp_data}), 64'h0);
        chk("rst_err", 64'({err, c3_err}), 64'h0);

        rst = 1'b0; bav = 1'b0; #1;
        chk("noaddr_ready", 64'(req_ready), 64'h0);
        tick();
        chk("noaddr_mreq_valid", 64'(mreq_valid), 64'h0);

        // Round robin: one grant per cycle, order 0,1,2,3,0,1
        bav = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_mreq_%0d", k), 64'({mreq_valid, mreq_write, mreq_tag, mreq_addr, mreq_data}),
                64'({1'b1, 1'((k % 4) % 2), 2'(k % 4), 8'h10 + 8'(k % 4), 16'hD000 + 16'(k % 4)}));
        end

        // Backpressure: register holds client 1, nothing else granted
        mreq_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_ready_%0d", k), 64'(req_ready), 64'h0);
            tick();
            chk($sformatf("bp_hold_%0d", k), 64'({mreq_valid, mreq_tag, mreq_addr}), 64'({1'b1, 2'd1, 8'h11}));
        end
        mreq_ready = 1'b1; #1;
        chk("drain_grant2", 64'(req_ready), 64'h4);
        tick();
        chk("drain_tag2", 64'(mreq_tag), 64'h2);
        chk("grant3", 64'(req_ready), 64'h8);
        tick();
        chk("all_at_limit", 64'(req_ready), 64'h0);
        tick();
        chk("reg_empty", 64'(mreq_valid), 64'h0);

        // Outstanding limit on client 1 alone, response frees a slot, grant+response same cycle
        req_valid = 4'b0010; rsp(1'b1, 2'd1, 16'h1111, 1'b1); #1;
        chk("lim_ready0", 64'(req_ready), 64'h0);
        tick();
        chk("lim_rsp", 64'({rsp_valid, rsp_write, rsp_data}), 64'({4'b0010, 1'b1, 16'h1111}));
        rsp(1'b1, 2'd1, 16'h2222, 1'b0); #1;
        chk("lim_regrant", 64'(req_ready), 64'h2);
        tick();
        rsp(1'b0, 2'd0, 16'h0, 1'b0); #1;
        chk("lim_same_cycle", 64'(req_ready), 64'h2);
        chk("lim_rsp2", 64'({rsp_valid, rsp_write, rsp_data}), 64'({4'b0010, 1'b0, 16'h2222}));
        tick();
        chk("lim_full_again", 64'(req_ready), 64'h0);
        chk("lim_rsp_gone", 64'(rsp_valid), 64'h0);

        // Response routing with tags 2,0,2 back to back
        req_valid = 4'b0000;
        rsp(1'b1, 2'd2, 16'h000A, 1'b0); tick();
        chk("route_a", 64'({rsp_valid, rsp_data}), 64'({4'b0100, 16'h000A}));
        rsp(1'b1, 2'd0, 16'h000B, 1'b1); tick();
        chk("route_b", 64'({rsp_valid, rsp_write, rsp_data}), 64'({4'b0001, 1'b1, 16'h000B}));
        rsp(1'b1, 2'd2, 16'h000C, 1'b0); tick();
        chk("route_c", 64'({rsp_valid, rsp_data}), 64'({4'b0100, 16'h000C}));
        rsp(1'b0, 2'd0, 16'h0, 1'b0); tick();
        chk("route_idle", 64'({rsp_valid, err}), 64'h0);

        // Response to client 2 with nothing outstanding: delivered, err set, counter stays 0
        rsp(1'b1, 2'd2, 16'h000D, 1'b0); tick();
        chk("zero_rsp", 64'({rsp_valid, rsp_data, err}), 64'({4'b0100, 16'h000D, 1'b1}));
        rsp(1'b0, 2'd0, 16'h0, 1'b0);
        req_valid = 4'b0100; #1;
        chk("zero_g1", 64'(req_ready), 64'h4);
        tick();
        chk("zero_g2", 64'(req_ready), 64'h4);
        tick();
        chk("zero_limit", 64'(req_ready), 64'h0);
        mreq_ready = 1'b0; tick();
        chk("err_sticky", 64'({err, mreq_valid, mreq_tag}), 64'({1'b1, 1'b1, 2'd2}));

        // Mid-operation reset discards the held request and clears err
        rst = 1'b1; #1;
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("mid_rst_state", 64'({err, mreq_valid, mreq_tag, rsp_valid}), 64'h0);
        rst = 1'b0; req_valid = 4'b0000; mreq_ready = 1'b1; tick();

        // Three-client instance: out-of-range tag dropped, zero-outstanding response delivered
        chk("c3_err_clear", 64'(c3_err), 64'h0);
        c3_mrsp_valid = 1'b1; c3_mrsp_tag = 2'd3; c3_mrsp_data = 16'h0033; tick();
        chk("c3_badtag", 64'({c3_rsp_valid, c3_err}), 64'({3'b000, 1'b1}));
        c3_mrsp_tag = 2'd1; c3_mrsp_data = 16'h0055; c3_mrsp_write = 1'b1; tick();
        chk("c3_zero_rsp", 64'({c3_rsp_valid, c3_rsp_write, c3_rsp_data, c3_err}),
            64'({3'b010, 1'b1, 16'h0055, 1'b1}));
        c3_mrsp_valid = 1'b0; tick(); tick();
        chk("c3_err_hold", 64'({c3_rsp_valid, c3_err}), 64'({3'b000, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-client memory arbiter between the `memory` block's single request/response channel and multiple requesters: the cpu plus future accelerator engines. It arbitrates requests round-robin, tags each with the client index, and limits per-client outstanding requests. It routes tagged responses back to the owning client, so the `memory` block can serve more than one master without modification.

## Interface
Parameters:
- NUM_CLIENTS, 2, number of requesters (2..8)
- ADDR_WIDTH, 42, cache-line address width
- DATA_WIDTH, 512, cache-line data width
- MAX_OUTSTANDING, 4, in-flight request limit per client (1..15)
- TAG_WIDTH, max(1, clog2(NUM_CLIENTS)), derived; width of the tag fields

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- buffer_addr_valid  in  1  shared buffer address programmed; no grant while low
- cl_req_valid  in  NUM_CLIENTS  per-client request valid
- cl_req_ready  out  NUM_CLIENTS  per-client grant (one-hot or zero)
- cl_req_write  in  NUM_CLIENTS  1 = write, 0 = read
- cl_req_addr  in  NUM_CLIENTS*ADDR_WIDTH  client i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- cl_req_data  in  NUM_CLIENTS*DATA_WIDTH  write data, same slicing
- cl_rsp_valid  out  NUM_CLIENTS  per-client response strobe, one cycle
- cl_rsp_write  out  1  response is a write ack
- cl_rsp_data  out  DATA_WIDTH  read data, shared by all clients
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts
- mem_req_write / mem_req_addr / mem_req_data / mem_req_tag  out  1 / ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH  downstream request fields; tag = client index
- mem_rsp_valid / mem_rsp_write / mem_rsp_tag / mem_rsp_data  in  1 / 1 / TAG_WIDTH / DATA_WIDTH  downstream response
- err  out  1  sticky protocol error

## Operation
- Output register: holds one request, with fields mem_req_* and an occupancy bit that drives mem_req_valid. The register can load when it is empty or being drained (mem_req_valid & mem_req_ready).
- Client i is eligible when all of the following hold:
  - cl_req_valid[i]
  - buffer_addr_valid
  - outstanding[i] < MAX_OUTSTANDING
  - the output register can load
- Arbitration: search starts at round-robin pointer rr_ptr; the first eligible client in the order rr_ptr, rr_ptr+1, … (mod NUM_CLIENTS) is granted.
  - cl_req_ready[g] is combinational and asserted in the same cycle.
  - The transfer happens on valid & ready.
  - On a grant, rr_ptr ← (g+1) mod NUM_CLIENTS. Without a grant, rr_ptr holds.
- Grant loads the output register with client g's write/addr/data and tag = g.
- outstanding[i]: 4-bit counter.
  - +1 on grant to i.
  - −1 on mem_rsp_valid with mem_rsp_tag == i.
  - Both in the same cycle: unchanged.
- Response path: on mem_rsp_valid, the next cycle drives cl_rsp_valid[mem_rsp_tag] = 1, with cl_rsp_write and cl_rsp_data registered from the mem_rsp_* inputs.
  - No backpressure; clients always accept.
  - Back-to-back responses give back-to-back strobes.
- Error cases (each sets err, sticky until rst):
  - mem_rsp_tag ≥ NUM_CLIENTS: response dropped, no strobe.
  - Response to a client whose outstanding = 0: counter stays 0, response still delivered.
- buffer_addr_valid falling: new grants stop immediately. An occupied output register is still presented until accepted, and responses continue to route.
- Request fields must stay stable while mem_req_valid & !mem_req_ready.

## Timing
- Reset values:
  - cl_req_ready = 0, cl_rsp_valid = 0, cl_rsp_write = 0, cl_rsp_data = 0
  - mem_req_valid = 0, mem_req_write/addr/data/tag = 0
  - err = 0, rr_ptr = 0, all outstanding = 0
- Request latency: grant in cycle N → mem_req_valid in cycle N+1.
- Throughput: one request per cycle while mem_req_ready = 1.
- Response latency: mem_rsp_valid in cycle M → cl_rsp_valid in cycle M+1.
- Reset mid-operation: everything clears in one cycle; the in-flight output request is discarded. Responses arriving after reset go through the outstanding = 0 rule.
- Idle power: no register toggles other than the occupancy bit when no valid is asserted.

## Test plan
- Reset check: assert rst 2 cycles with all clients valid → all outputs 0, no grant. Release with buffer_addr_valid = 0 → still no grant.
- Round-robin: NUM_CLIENTS = 4, all valid, mem_req_ready = 1 → grant order 0,1,2,3,0,1…; mem_req_tag follows; one request per cycle.
- Backpressure: mem_req_ready = 0 for 5 cycles after the first grant → mem_req_* stable and no further cl_req_ready. Ready high again → next client granted the same cycle the register drains.
- Outstanding limit: MAX_OUTSTANDING = 2, client 1 alone, no responses → exactly 2 grants, then ready stays 0. One response with tag 1 → third grant the cycle after. Simultaneous grant and response → counter unchanged.
- Response routing: responses with tags 2,0,2 on consecutive cycles, data 0xA,0xB,0xC → cl_rsp_valid = 4'b0100, 4'b0001, 4'b0100 on the following cycles, with matching data.
- Errors: NUM_CLIENTS = 3, response tag 3 → no strobe, err = 1. Response to a client with 0 outstanding → delivered, err = 1. err holds until rst.
